// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencing controller.
package pc_ctrl_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } pc_fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of hazard/branch inputs, imem handshake and PC-register controls.
interface pc_fetch_ctrl_if
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             i_br_taken;
    logic [XLEN-1:0]  i_br_target;
    logic             i_hazard_stall;
    logic             i_imem_ack;
    logic             o_imem_req;
    logic             o_pc_en;
    logic             o_pc_sel;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             o_if_valid;
    logic             o_flush_ifid;
    logic             o_flush_idex;
    logic [CNT_W-1:0] o_stall_cycles;

    // The controller owns every o_* signal.
    modport master (
        input  i_br_taken, i_br_target, i_hazard_stall, i_imem_ack,
        output o_imem_req, o_pc_en, o_pc_sel, o_redirect_pc, o_if_valid,
        output o_flush_ifid, o_flush_idex, o_stall_cycles
    );

    modport slave (
        output i_br_taken, i_br_target, i_hazard_stall, i_imem_ack,
        input  o_imem_req, o_pc_en, o_pc_sel, o_redirect_pc, o_if_valid,
        input  o_flush_ifid, o_flush_idex, o_stall_cycles
    );

endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (v == {WIDTH{1'b1}})
            return v;
        return v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            count_q <= '0;
        else if (i_inc)
            count_q <= sat_inc(count_q);
    end

    assign o_count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: chooses advance / hold / redirect for the PC register each cycle.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    pc_fetch_ctrl_if.master bus
);

    pc_fetch_state_e state_q, state_d;
    logic [XLEN-1:0] redir_q, redir_d;

    logic            pc_en;
    logic            pc_sel;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            flush;
    logic            stall_inc;
    logic [CNT_W-1:0] stall_cycles;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    // A branch always outranks a load-use stall; the youngest branch owns the redirect register.
    always_comb begin
        state_d     = state_q;
        redir_d     = redir_q;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        redirect_pc = '0;
        if_valid    = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                redirect_pc = redir_q;
                if (bus.i_br_taken && bus.i_imem_ack) begin
                    pc_en       = 1'b1;
                    pc_sel      = 1'b1;
                    redirect_pc = bus.i_br_target;
                    flush       = 1'b1;
                end else if (bus.i_br_taken) begin
                    redir_d = bus.i_br_target;
                    flush   = 1'b1;
                    state_d = DRAIN;
                end else if (bus.i_imem_ack && bus.i_hazard_stall) begin
                    if_valid = 1'b1;
                    state_d  = HOLD;
                end else if (bus.i_imem_ack) begin
                    if_valid = 1'b1;
                    pc_en    = 1'b1;
                end
            end
            HOLD: begin
                redirect_pc = redir_q;
                if (bus.i_br_taken) begin
                    pc_en       = 1'b1;
                    pc_sel      = 1'b1;
                    redirect_pc = bus.i_br_target;
                    flush       = 1'b1;
                    state_d     = FETCH;
                end else if (!bus.i_hazard_stall) begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // The word arriving here belongs to the squashed path and is dropped.
                redirect_pc = redir_q;
                if (bus.i_br_taken) begin
                    redir_d = bus.i_br_target;
                    flush   = 1'b1;
                    if (bus.i_imem_ack) begin
                        pc_en       = 1'b1;
                        pc_sel      = 1'b1;
                        redirect_pc = bus.i_br_target;
                        state_d     = FETCH;
                    end
                end else if (bus.i_imem_ack) begin
                    pc_en   = 1'b1;
                    pc_sel  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_inc = ((state_q == FETCH) || (state_q == HOLD)) && !pc_en;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (stall_inc),
        .o_count (stall_cycles)
    );

    assign bus.o_imem_req     = (state_q == FETCH);
    assign bus.o_pc_en        = pc_en;
    assign bus.o_pc_sel       = pc_sel;
    assign bus.o_redirect_pc  = redirect_pc;
    assign bus.o_if_valid     = if_valid;
    assign bus.o_flush_ifid   = flush;
    assign bus.o_flush_idex   = flush;
    assign bus.o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized bench for pc_fetch_ctrl against a behavioural reference model.
module tb_pc_fetch_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: "booting" until the first edge out of reset, then
    // either fetching normally, holding a stalled word, or waiting for the
    // outstanding (squashed) fetch to come back before redirecting.
    bit              m_boot, m_drain, m_hold;
    logic [XLEN-1:0] m_target;
    longint          m_count;

    bit              e_req, e_en, e_sel, e_val, e_fl, e_rpc_chk;
    logic [XLEN-1:0] e_rpc;
    bit              nx_drain, nx_hold;
    logic [XLEN-1:0] nx_target;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_boot   = 1'b1;
        m_drain  = 1'b0;
        m_hold   = 1'b0;
        m_target = '0;
        m_count  = 0;
    endtask

    task automatic model_eval(input bit br, input logic [XLEN-1:0] tgt, input bit st, input bit ack);
        e_req = 0; e_en = 0; e_sel = 0; e_val = 0; e_fl = 0; e_rpc = '0; e_rpc_chk = 0;
        nx_drain = m_drain; nx_hold = m_hold; nx_target = m_target;
        if (m_boot) begin
            e_rpc_chk = 1;
        end else if (m_drain) begin
            if (br) begin
                e_fl = 1; nx_target = tgt;
                if (ack) begin e_en = 1; e_sel = 1; e_rpc = tgt; nx_drain = 0; end
            end else if (ack) begin
                e_en = 1; e_sel = 1; e_rpc = m_target; nx_drain = 0;
            end
        end else if (m_hold) begin
            if (br) begin
                e_en = 1; e_sel = 1; e_rpc = tgt; e_fl = 1; nx_hold = 0;
            end else if (!st) begin
                e_en = 1; nx_hold = 0;
            end
        end else begin
            e_req = 1;
            if (br && ack) begin e_en = 1; e_sel = 1; e_rpc = tgt; e_fl = 1; end
            else if (br) begin e_fl = 1; nx_drain = 1; nx_target = tgt; end
            else if (ack && st) begin e_val = 1; nx_hold = 1; end
            else if (ack) begin e_val = 1; e_en = 1; end
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_reset();
        end else begin
            if (!m_boot && !m_drain && !e_en && m_count < CNT_MAX)
                m_count = m_count + 1;
            m_boot   = 0;
            m_drain  = nx_drain;
            m_hold   = nx_hold;
            m_target = nx_target;
        end
    endtask

    // Entered and left on a falling edge.
    task automatic cyc(input bit br, input logic [XLEN-1:0] tgt, input bit st, input bit ack,
                       input string tag);
        bus.i_br_taken     = br;
        bus.i_br_target    = tgt;
        bus.i_hazard_stall = st;
        bus.i_imem_ack     = ack;
        #1;
        model_eval(br, tgt, st, ack);
        chk({tag, "/req"},   bus.o_imem_req,     e_req);
        chk({tag, "/pc_en"}, bus.o_pc_en,        e_en);
        chk({tag, "/sel"},   bus.o_pc_sel,       e_sel);
        chk({tag, "/valid"}, bus.o_if_valid,     e_val);
        chk({tag, "/fl_if"}, bus.o_flush_ifid,   e_fl);
        chk({tag, "/fl_id"}, bus.o_flush_idex,   e_fl);
        chk({tag, "/cnt"},   bus.o_stall_cycles, m_count);
        if (e_rpc_chk || e_sel)
            chk({tag, "/rpc"}, bus.o_redirect_pc, e_rpc);
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
    endtask

    initial begin
        bus.i_br_taken     = 1'b0;
        bus.i_br_target    = '0;
        bus.i_hazard_stall = 1'b0;
        bus.i_imem_ack     = 1'b0;
        m_reset();

        @(negedge clk);
        cyc(0, '0, 0, 1, "in_reset");
        rst_n = 1'b1;

        cyc(0, '0, 0, 1, "rst_rel");
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, "ack_run");

        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 1, "load_use");
        cyc(0, '0, 0, 0, "stall_rel");
        chk("stall_cnt3", bus.o_stall_cycles, 3);

        cyc(1, 32'h0000_0100, 0, 1, "br_ack");
        cyc(0, '0, 0, 1, "post_br");

        cyc(1, 32'h0000_0200, 0, 0, "br_noack");
        cyc(0, '0, 0, 0, "drain_w1");
        cyc(0, '0, 0, 0, "drain_w2");
        cyc(0, '0, 0, 1, "drain_ack");

        cyc(1, 32'h0000_0280, 1, 0, "br_stall");
        cyc(1, 32'h0000_0300, 0, 0, "br2_drain");
        cyc(0, '0, 0, 1, "drain_young");

        cyc(0, '0, 1, 1, "hold_in");
        cyc(1, 32'h0000_0400, 1, 0, "hold_br");
        cyc(0, '0, 0, 1, "hold_post");

        // Asynchronous reset while a redirect is pending
        cyc(1, 32'h0000_0500, 0, 0, "pre_rst");
        bus.i_br_taken = 1'b1;
        bus.i_imem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst/req",   bus.o_imem_req,     0);
        chk("arst/pc_en", bus.o_pc_en,        0);
        chk("arst/sel",   bus.o_pc_sel,       0);
        chk("arst/rpc",   bus.o_redirect_pc,  0);
        chk("arst/valid", bus.o_if_valid,     0);
        chk("arst/fl_if", bus.o_flush_ifid,   0);
        chk("arst/fl_id", bus.o_flush_idex,   0);
        chk("arst/cnt",   bus.o_stall_cycles, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, '0, 0, 1, "late_ack");

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 15), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60), "rand");
        end

        // Counter pinned at saturation must not wrap on further stalls
        force dut.u_stall_cnt.count_q = '1;
        #1;
        release dut.u_stall_cnt.count_q;
        m_count = CNT_MAX;
        cyc(0, '0, 0, 1, "sat_a");
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, "sat_b");
        cyc(0, '0, 1, 1, "sat_c");
        cyc(0, '0, 1, 0, "sat_d");
        chk("sat_final", bus.o_stall_cycles, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
